mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single-port unified instruction/data memory between the instruction-fetch path (IF) and the load/store path (LS). It grants one requester at a time, drives a registered command onto the memory port, waits a fixed read latency, and returns one response pulse to the owner. It sits between the multi-cycle controller/datapath and the memory, and replaces direct controller-driven memory write enables.

## Interface
- WIDTH, 32, data width in bits; multiple of 8
- ADDR_WIDTH, 32, address width in bits
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; must be >= 1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  IF request (level); held with if_addr until if_gnt
- if_addr  in  ADDR_WIDTH  IF word address
- if_gnt  out  1  IF request accepted (combinational, one cycle)
- if_rvalid  out  1  IF read data valid (one-cycle pulse)
- if_rdata  out  WIDTH  IF read data; held until next IF read response
- ls_req  in  1  LS request (level); held with all ls_* fields until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_WIDTH  LS address
- ls_wdata  in  WIDTH  store data
- ls_be  in  WIDTH/8  store byte enables
- ls_gnt  out  1  LS request accepted (combinational, one cycle)
- ls_rvalid  out  1  LS response pulse (load data valid or store done)
- ls_rdata  out  WIDTH  LS load data; held until next LS load response
- mem_en, mem_we  out  1 each  memory command strobe / write
- mem_addr  out  ADDR_WIDTH; mem_wdata  out  WIDTH; mem_be  out  WIDTH/8
- mem_rdata  in  WIDTH  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP. One transaction outstanding at most.
- IDLE: if any req high, assert winner's gnt this cycle, latch its command (IF: we=0, be=all ones, wdata=0) and owner, go ISSUE. No req: stay.
- Arbitration: round robin on contention; winner is the requester not granted last. last_owner resets to LS, so first contention goes to IF. A lone requester always wins; last_owner updates on every grant.
- ISSUE: mem_en=1 with latched mem_we/addr/wdata/be (registered outputs, one cycle only); load counter with MEM_LATENCY; go WAIT.
- WAIT: decrement counter each cycle; on last WAIT cycle (counter==1) capture mem_rdata into owner's rdata register if transaction is a read; go RESP.
- RESP: owner's rvalid=1 for exactly this cycle; go IDLE. Stores pulse ls_rvalid but leave ls_rdata unchanged.
- gnt never asserted outside IDLE; requests arriving in ISSUE/WAIT/RESP wait (requester holds req).
- Requester holding req through RESP is re-arbitrated in the next IDLE cycle against the other.
- mem_* outputs outside ISSUE: mem_en=0, mem_we=0; addr/wdata/be don't care but hold last value.
- Counter width $clog2(MEM_LATENCY+1).

## Timing
- Reset (async): state=IDLE, last_owner=LS, all gnt/rvalid/mem_en/mem_we=0, mem_addr/wdata/be=0, if_rdata=ls_rdata=0.
- Grant in cycle T0; mem_en in T1; mem_rdata sampled end of T1+MEM_LATENCY; rvalid in T2+MEM_LATENCY; next grant earliest T3+MEM_LATENCY. Per-transaction occupancy MEM_LATENCY+3 cycles.
- rst mid-transaction: command aborted, no rvalid issued for it, rdata registers cleared; first grant possible in first cycle after rst deasserts.
- Simultaneous if_req and ls_req in IDLE: exactly one gnt, per round robin; never both.

## Test plan
- Reset then if_req, if_addr=0x10, mem returns 0x00500093, MEM_LATENCY=1 -> if_gnt at T0, mem_en/addr=0x10 at T1, if_rvalid with if_rdata=0x00500093 at T3, IDLE at T4.
- ls_req store, ls_addr=0x100, ls_wdata=0xDEADBEEF, ls_be=0x3 -> mem_en=1, mem_we=1, mem_be=0x3 one cycle; ls_rvalid pulse; ls_rdata unchanged (0).
- if_req and ls_req both held high continuously -> grants alternate IF, LS, IF, LS; each spaced MEM_LATENCY+3 cycles; no double gnt.
- MEM_LATENCY=3, load from 0x20 returning 0x12345678 -> ls_rvalid exactly 5 cycles after ls_gnt with ls_rdata=0x12345678.
- rst asserted during WAIT of an IF read -> all outputs zero immediately, no if_rvalid; subsequent ls_req served normally.
- ls_req asserted during an IF transaction's WAIT -> ls_gnt first asserted in the IDLE cycle after if_rvalid, not earlier.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// (IF) and load/store (LS) paths. One transaction in flight at a time. The
// command is registered onto the memory port, the fixed read latency is
// waited out, and one response pulse is returned to the owner.
module mem_arbiter #(
    parameter int WIDTH       = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction-fetch port
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [WIDTH-1:0]      if_rdata,
    // load/store port
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [WIDTH-1:0]      ls_wdata,
    input  logic [WIDTH/8-1:0]    ls_be,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [WIDTH-1:0]      ls_rdata,
    // memory port
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic [WIDTH/8-1:0]    mem_be,
    input  logic [WIDTH-1:0]      mem_rdata
);

    localparam int BE_W  = WIDTH / 8;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    owner_t                last_owner_q, last_owner_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cmd_we_q, cmd_we_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]       mem_be_q, mem_be_d;
    logic [WIDTH-1:0]      if_rdata_q, if_rdata_d;
    logic [WIDTH-1:0]      ls_rdata_q, ls_rdata_d;

    logic                  pick_if;

    // Round robin: on contention the requester not granted last wins; a lone
    // requester always wins.
    assign pick_if = if_req && (!ls_req || (last_owner_q == OWN_LS));

    // Next-state, grant and memory-command logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        cmd_we_d     = cmd_we_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        if_rdata_d   = if_rdata_q;
        ls_rdata_d   = ls_rdata_q;
        if_gnt       = 1'b0;
        ls_gnt       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Grants are suppressed while reset is held so every output
                // reads zero during reset.
                if (!rst && pick_if) begin
                    if_gnt       = 1'b1;
                    owner_d      = OWN_IF;
                    last_owner_d = OWN_IF;
                    cmd_we_d     = 1'b0;
                    mem_en_d     = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = '0;
                    mem_be_d     = '1;
                    state_d      = S_ISSUE;
                end else if (!rst && ls_req) begin
                    ls_gnt       = 1'b1;
                    owner_d      = OWN_LS;
                    last_owner_d = OWN_LS;
                    cmd_we_d     = ls_we;
                    mem_en_d     = 1'b1;
                    mem_we_d     = ls_we;
                    mem_addr_d   = ls_addr;
                    mem_wdata_d  = ls_wdata;
                    mem_be_d     = ls_be;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // mem_en is high for this cycle only; start the latency count.
                cnt_d   = CNT_W'(MEM_LATENCY);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Read data is valid in the last wait cycle; stores leave
                    // the load-data register untouched.
                    if (!cmd_we_q) begin
                        if (owner_q == OWN_IF) begin
                            if_rdata_d = mem_rdata;
                        end else begin
                            ls_rdata_d = mem_rdata;
                        end
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered memory-port / read-data storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_LS;
            last_owner_q <= OWN_LS;
            cnt_q        <= '0;
            cmd_we_q     <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            cmd_we_q     <= cmd_we_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign if_rvalid = (state_q == S_RESP) && (owner_q == OWN_IF);
    assign ls_rvalid = (state_q == S_RESP) && (owner_q == OWN_LS);

endmodule
